hazard_unit: RTL and testbench

- Pipeline control block for the 5-stage MIPS datapath. Sits beside the forwarding logic and drives the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB latch enables and flushes.
- Handles the cases forwarding cannot cover:
  - load-use bubbles;
  - data-memory wait (load/store in MEM without dhit);
  - taken branch/jump flushes resolved in EX;
  - instruction-fetch wait;
  - halt.
- Keeps saturating per-cause stall counters for performance readout.

---
 rtl/cpu_types_pkg.sv | 12 +
 rtl/hazard_unit_if.sv | 46 ++++
 rtl/sat_counter.sv | 31 +++
 rtl/hazard_unit.sv | 116 +++++++++++
 tb/tb_hazard_unit.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared pipeline control types and constants
package cpu_types_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DWAIT  = 2'd1,
    HALTED = 2'd2
  } hazard_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_unit_if.sv
// rtl/hazard_unit_if.sv - signal bundle between the hazard unit and its surroundings
interface hazard_unit_if #(
  parameter int CNT_W = 16
) (
  input logic CLK
);
  logic             RST;
  logic             ihit;
  logic             dhit;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             ex_RegWr;
  logic             ex_MemtoReg;
  logic [4:0]       ex_WrDest;
  logic             ex_pcsrc_taken;
  logic             mem_dREN;
  logic             mem_dWEN;
  logic             mem_halt;
  logic             pc_en;
  logic             ifid_en;
  logic             ifid_flush;
  logic             idex_en;
  logic             idex_flush;
  logic             exmem_en;
  logic             memwb_en;
  logic             memwb_flush;
  logic             halted;
  logic [CNT_W-1:0] cnt_loaduse;
  logic [CNT_W-1:0] cnt_dwait;
  logic [CNT_W-1:0] cnt_flush;

  modport haz (
    input  CLK, RST, ihit, dhit, id_rs, id_rt, ex_RegWr, ex_MemtoReg, ex_WrDest,
           ex_pcsrc_taken, mem_dREN, mem_dWEN, mem_halt,
    output pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en,
           memwb_flush, halted, cnt_loaduse, cnt_dwait, cnt_flush
  );

  modport tb (
    input  CLK, pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en,
           memwb_flush, halted, cnt_loaduse, cnt_dwait, cnt_flush,
    output RST, ihit, dhit, id_rs, id_rt, ex_RegWr, ex_MemtoReg, ex_WrDest,
           ex_pcsrc_taken, mem_dREN, mem_dWEN, mem_halt
  );

endinterface

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter with synchronous clear
module sat_counter #(
  parameter int W = 16
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - stall/flush control for the 5-stage pipeline with stall counters
module hazard_unit
  import cpu_types_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             ex_RegWr,
  input  logic             ex_MemtoReg,
  input  logic [4:0]       ex_WrDest,
  input  logic             ex_pcsrc_taken,
  input  logic             mem_dREN,
  input  logic             mem_dWEN,
  input  logic             mem_halt,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             memwb_flush,
  output logic             halted,
  output logic [CNT_W-1:0] cnt_loaduse,
  output logic [CNT_W-1:0] cnt_dwait,
  output logic [CNT_W-1:0] cnt_flush
);

  hazard_state_t state_q;

  logic freeze;
  logic lu;
  logic active;
  logic inc_lu;
  logic inc_dwait;
  logic inc_flush;

  assign freeze = (mem_dREN | mem_dWEN) & ~dhit;
  assign lu     = ex_RegWr & ex_MemtoReg & (ex_WrDest != REG_ZERO) &
                  ((ex_WrDest == id_rs) | (ex_WrDest == id_rt));
  assign active = ~RST & (state_q != HALTED);

  // Each counter only ticks when its cause is the one that wins priority.
  assign inc_dwait = active & freeze;
  assign inc_flush = active & ~freeze & ex_pcsrc_taken;
  assign inc_lu    = active & ~freeze & ~ex_pcsrc_taken & lu;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= RUN;
    end else begin
      case (state_q)
        RUN: begin
          if (mem_halt && !freeze) state_q <= HALTED;
          else if (freeze)         state_q <= DWAIT;
        end
        DWAIT: begin
          if (mem_halt && !freeze) state_q <= HALTED;
          else if (dhit)           state_q <= RUN;
        end
        default: state_q <= HALTED;
      endcase
    end
  end

  // Signals not named by a case stay 0; a flush loads its latch regardless of en.
  always_comb begin
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    ifid_flush  = 1'b0;
    idex_en     = 1'b0;
    idex_flush  = 1'b0;
    exmem_en    = 1'b0;
    memwb_en    = 1'b0;
    memwb_flush = 1'b0;
    if (!active) begin
      pc_en = 1'b0;
    end else if (freeze) begin
      memwb_en    = 1'b1;
      memwb_flush = 1'b1;
    end else if (ex_pcsrc_taken) begin
      pc_en      = 1'b1;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      exmem_en   = 1'b1;
      memwb_en   = 1'b1;
    end else if (lu) begin
      idex_flush = 1'b1;
      exmem_en   = 1'b1;
      memwb_en   = 1'b1;
    end else if (!ihit) begin
      ifid_flush = 1'b1;
      idex_en    = 1'b1;
      exmem_en   = 1'b1;
      memwb_en   = 1'b1;
    end else begin
      pc_en    = 1'b1;
      ifid_en  = 1'b1;
      idex_en  = 1'b1;
      exmem_en = 1'b1;
      memwb_en = 1'b1;
    end
  end

  assign halted = ~RST & (state_q == HALTED);

  sat_counter #(.W(CNT_W)) u_cnt_loaduse (.CLK(CLK), .RST(RST), .inc(inc_lu),    .count(cnt_loaduse));
  sat_counter #(.W(CNT_W)) u_cnt_dwait   (.CLK(CLK), .RST(RST), .inc(inc_dwait), .count(cnt_dwait));
  sat_counter #(.W(CNT_W)) u_cnt_flush   (.CLK(CLK), .RST(RST), .inc(inc_flush), .count(cnt_flush));

endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - directed self-checking bench for hazard_unit
module tb_hazard_unit;
  import cpu_types_pkg::*;

  // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en, memwb_flush, halted}
  localparam logic [8:0] V_OFF    = 9'b000000000;
  localparam logic [8:0] V_RUN    = 9'b110101100;
  localparam logic [8:0] V_FREEZE = 9'b000000110;
  localparam logic [8:0] V_TAKEN  = 9'b101011100;
  localparam logic [8:0] V_LU     = 9'b000011100;
  localparam logic [8:0] V_NOHIT  = 9'b001101100;
  localparam logic [8:0] V_HALT   = 9'b000000001;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  hazard_unit_if #(.CNT_W(16)) hif (.CLK(CLK));

  hazard_unit #(.CNT_W(16)) dut (
    .CLK            (CLK),
    .RST            (hif.RST),
    .ihit           (hif.ihit),
    .dhit           (hif.dhit),
    .id_rs          (hif.id_rs),
    .id_rt          (hif.id_rt),
    .ex_RegWr       (hif.ex_RegWr),
    .ex_MemtoReg    (hif.ex_MemtoReg),
    .ex_WrDest      (hif.ex_WrDest),
    .ex_pcsrc_taken (hif.ex_pcsrc_taken),
    .mem_dREN       (hif.mem_dREN),
    .mem_dWEN       (hif.mem_dWEN),
    .mem_halt       (hif.mem_halt),
    .pc_en          (hif.pc_en),
    .ifid_en        (hif.ifid_en),
    .ifid_flush     (hif.ifid_flush),
    .idex_en        (hif.idex_en),
    .idex_flush     (hif.idex_flush),
    .exmem_en       (hif.exmem_en),
    .memwb_en       (hif.memwb_en),
    .memwb_flush    (hif.memwb_flush),
    .halted         (hif.halted),
    .cnt_loaduse    (hif.cnt_loaduse),
    .cnt_dwait      (hif.cnt_dwait),
    .cnt_flush      (hif.cnt_flush)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] outs();
    return {hif.pc_en, hif.ifid_en, hif.ifid_flush, hif.idex_en, hif.idex_flush,
            hif.exmem_en, hif.memwb_en, hif.memwb_flush, hif.halted};
  endfunction

  task automatic set_idle();
    hif.ihit           = 1'b1;
    hif.dhit           = 1'b0;
    hif.id_rs          = 5'd0;
    hif.id_rt          = 5'd0;
    hif.ex_RegWr       = 1'b0;
    hif.ex_MemtoReg    = 1'b0;
    hif.ex_WrDest      = 5'd0;
    hif.ex_pcsrc_taken = 1'b0;
    hif.mem_dREN       = 1'b0;
    hif.mem_dWEN       = 1'b0;
    hif.mem_halt       = 1'b0;
  endtask

  task automatic set_load_use(input logic [4:0] dest, input logic [4:0] rs, input logic [4:0] rt);
    hif.ex_RegWr    = 1'b1;
    hif.ex_MemtoReg = 1'b1;
    hif.ex_WrDest   = dest;
    hif.id_rs       = rs;
    hif.id_rt       = rt;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    hif.RST = 1'b1;
    set_idle();
    #1;
    check_eq("reset_outs", 32'(outs()), 32'(V_OFF));
    tick();
    check_eq("reset_state", 32'(dut.state_q), 32'(RUN));
    check_eq("reset_cnt_lu", 32'(hif.cnt_loaduse), 32'd0);
    hif.RST = 1'b0;
    #1;
    check_eq("idle_run", 32'(outs()), 32'(V_RUN));

    // load-use bubble, then the load moves to MEM and hits
    set_load_use(5'd2, 5'd2, 5'd7);
    #1;
    check_eq("lu_outs", 32'(outs()), 32'(V_LU));
    tick();
    check_eq("lu_cnt", 32'(hif.cnt_loaduse), 32'd1);
    set_idle();
    hif.mem_dREN = 1'b1;
    hif.dhit     = 1'b1;
    #1;
    check_eq("lu_after", 32'(outs()), 32'(V_RUN));
    tick();

    // $0 destination and non-load producer never bubble
    set_idle();
    set_load_use(5'd0, 5'd0, 5'd0);
    #1;
    check_eq("lu_reg0", 32'(outs()), 32'(V_RUN));
    tick();
    set_load_use(5'd5, 5'd1, 5'd5);
    hif.ex_MemtoReg = 1'b0;
    #1;
    check_eq("lu_nonload", 32'(outs()), 32'(V_RUN));
    tick();
    check_eq("lu_cnt_hold", 32'(hif.cnt_loaduse), 32'd1);

    set_idle();
    hif.ihit = 1'b0;
    #1;
    check_eq("nohit", 32'(outs()), 32'(V_NOHIT));
    tick();

    // data memory wait: three frozen cycles, then advance on dhit
    set_idle();
    hif.mem_dREN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("dwait_freeze", 32'(outs()), 32'(V_FREEZE));
      tick();
      check_eq("dwait_state", 32'(dut.state_q), 32'(DWAIT));
    end
    check_eq("dwait_cnt", 32'(hif.cnt_dwait), 32'd3);
    hif.dhit = 1'b1;
    #1;
    check_eq("dwait_release", 32'(outs()), 32'(V_RUN));
    tick();
    check_eq("dwait_back_run", 32'(dut.state_q), 32'(RUN));

    // branch held in EX while a store waits
    set_idle();
    hif.ex_pcsrc_taken = 1'b1;
    hif.mem_dWEN       = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      check_eq("br_frz_outs", 32'(outs()), 32'(V_FREEZE));
      tick();
    end
    check_eq("br_frz_noflushcnt", 32'(hif.cnt_flush), 32'd0);
    hif.dhit = 1'b1;
    #1;
    check_eq("br_frz_release", 32'(outs()), 32'(V_TAKEN));
    tick();
    check_eq("br_frz_cnt", 32'(hif.cnt_flush), 32'd1);
    check_eq("br_frz_dwait", 32'(hif.cnt_dwait), 32'd5);

    // branch beats load-use and fetch miss
    set_idle();
    set_load_use(5'd3, 5'd4, 5'd3);
    hif.ex_pcsrc_taken = 1'b1;
    hif.ihit           = 1'b0;
    #1;
    check_eq("br_prio_outs", 32'(outs()), 32'(V_TAKEN));
    tick();
    check_eq("br_prio_flushcnt", 32'(hif.cnt_flush), 32'd2);
    check_eq("br_prio_lucnt", 32'(hif.cnt_loaduse), 32'd1);

    // drive cnt_loaduse to saturation, then one extra event
    set_idle();
    set_load_use(5'd9, 5'd9, 5'd0);
    for (int i = 0; i < 65534; i++) begin
      @(posedge CLK);
    end
    #1;
    check_eq("sat_reach", 32'(hif.cnt_loaduse), 32'h0000_FFFF);
    tick();
    check_eq("sat_hold", 32'(hif.cnt_loaduse), 32'h0000_FFFF);

    // halt is sticky and freezes the counters
    set_idle();
    hif.mem_halt = 1'b1;
    #1;
    check_eq("halt_entry", 32'(outs()), 32'(V_RUN));
    tick();
    check_eq("halt_outs", 32'(outs()), 32'(V_HALT));
    set_idle();
    set_load_use(5'd4, 5'd4, 5'd0);
    hif.mem_dREN = 1'b1;
    #1;
    check_eq("halt_sticky", 32'(outs()), 32'(V_HALT));
    tick();
    tick();
    check_eq("halt_state", 32'(dut.state_q), 32'(HALTED));
    check_eq("halt_dwait_frozen", 32'(hif.cnt_dwait), 32'd5);

    // reset leaves HALTED and clears counters
    set_idle();
    hif.RST = 1'b1;
    #1;
    check_eq("rst_outs", 32'(outs()), 32'(V_OFF));
    tick();
    hif.RST = 1'b0;
    #1;
    check_eq("rst_state", 32'(dut.state_q), 32'(RUN));
    check_eq("rst_run", 32'(outs()), 32'(V_RUN));
    check_eq("rst_cnt_lu", 32'(hif.cnt_loaduse), 32'd0);
    check_eq("rst_cnt_dwait", 32'(hif.cnt_dwait), 32'd0);
    check_eq("rst_cnt_flush", 32'(hif.cnt_flush), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
